// File: rtl/ascon_pkg.sv
// ascon_pkg: shared Ascon types, round-count constants and the arbiter FSM encoding.
//   ascon_state_t : 320-bit permutation state, layout {x4,x3,x2,x1,x0}
//   rounds_t      : 4-bit round count
//   rounds_ok()   : true when a round count is runnable (1..max_r)
package ascon_pkg;
  typedef logic [319:0] ascon_state_t;
  typedef logic [3:0] rounds_t;
  localparam int ASCON_ROUNDS_A = 12;
  localparam int ASCON_ROUNDS_B = 6;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
  function automatic logic rounds_ok(input rounds_t r, input int max_r);
    return (r != '0) && (int'(r) <= max_r);
  endfunction
endpackage

// File: rtl/ascon_perm_arbiter_if.sv
// ascon_perm_arbiter_if: requester-side bus of the permutation arbiter.
//   req/req_rounds/req_state : packed per-requester request, slot i at [w*i +: w]
//   gnt/rsp_valid            : one-hot grant and one-cycle response pulse
//   rsp_err/rsp_state        : response qualifier and permuted state
//   modports: slave (arbiter side), master (requester side)
interface ascon_perm_arbiter_if #(parameter int N_REQ = 2);
  import ascon_pkg::*;
  logic [N_REQ-1:0] req;
  logic [4*N_REQ-1:0] req_rounds;
  logic [320*N_REQ-1:0] req_state;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] rsp_valid;
  logic rsp_err;
  ascon_state_t rsp_state;
  modport slave (input req, req_rounds, req_state, output gnt, rsp_valid, rsp_err, rsp_state);
  modport master (output req, req_rounds, req_state, input gnt, rsp_valid, rsp_err, rsp_state);
endinterface

// File: rtl/ascon_perm_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req : request vector; ptr : highest-priority index
//   gnt : one-hot grant of the first set req at or after ptr (wrapping)
//   idx : index of that grant; any : at least one request pending
module rr_pick #(
  parameter int N = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] j;
  // Scan from farthest to nearest so the nearest set bit overwrites the rest.
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) idx = j;
    end
  end
  assign any = |req;
  assign gnt = any ? (N'(1) << idx) : '0;
endmodule

// File: rtl/ascon_perm_arbiter.sv
// ascon_perm_arbiter: round-robin sharing of one Ascon permutation core between N_REQ requesters.
//   clk, rst_n          : clock, asynchronous active-low reset
//   rq (slave)          : requester bus (req/rounds/state in, gnt/rsp_* out)
//   perm_start/rounds/state_in, perm_done/state_out : core handshake
//   perm_abort          : watchdog abort pulse, present only with ASCON_ARB_TIMEOUT_EN
//   busy                : FSM not in IDLE
// Optional feature macro: ASCON_ARB_TIMEOUT_EN (WAIT watchdog of TIMEOUT cycles).
module ascon_perm_arbiter
  import ascon_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int MAX_ROUNDS = ASCON_ROUNDS_A,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ascon_perm_arbiter_if.slave  rq,
  output logic                 perm_start,
  output rounds_t              perm_rounds,
  output ascon_state_t         perm_state_in,
  input  logic                 perm_done,
  input  ascon_state_t         perm_state_out,
`ifdef ASCON_ARB_TIMEOUT_EN
  output logic                 perm_abort,
`endif
  output logic                 busy
);
  localparam int IW = $clog2(N_REQ);
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1 || MAX_ROUNDS > 15) begin : g_bad_cfg
    $error("ascon_perm_arbiter: unsupported parameter set");
  end
  arb_state_e st;
  logic [IW-1:0] ptr, gidx, pidx;
  logic [N_REQ-1:0] pgnt;
  logic pany;
  rounds_t srounds;
  ascon_state_t sstate;
`ifdef ASCON_ARB_TIMEOUT_EN
  logic [$clog2(TIMEOUT+1)-1:0] cnt;
`endif
  rr_pick #(.N(N_REQ)) u_pick (.req(rq.req), .ptr(ptr), .gnt(pgnt), .idx(pidx), .any(pany));
  assign srounds = rounds_t'(rq.req_rounds >> (4 * pidx));
  assign sstate = ascon_state_t'(rq.req_state >> (320 * pidx));
  assign busy = st != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      ptr <= '0;
      gidx <= '0;
      rq.gnt <= '0;
      rq.rsp_valid <= '0;
      rq.rsp_err <= 1'b0;
      rq.rsp_state <= '0;
      perm_start <= 1'b0;
      perm_rounds <= '0;
      perm_state_in <= '0;
`ifdef ASCON_ARB_TIMEOUT_EN
      perm_abort <= 1'b0;
      cnt <= '0;
`endif
    end else begin
      perm_start <= 1'b0;
      rq.rsp_valid <= '0;
`ifdef ASCON_ARB_TIMEOUT_EN
      perm_abort <= 1'b0;
`endif
      case (st)
        IDLE: if (pany) begin
          rq.gnt <= pgnt;
          gidx <= pidx;
          perm_rounds <= srounds;
          perm_state_in <= sstate;
          // Start is registered here so the core sees it in the ISSUE cycle.
          perm_start <= rounds_ok(srounds, MAX_ROUNDS);
          st <= ISSUE;
        end
        ISSUE: begin
`ifdef ASCON_ARB_TIMEOUT_EN
          cnt <= '0;
`endif
          if (!rounds_ok(perm_rounds, MAX_ROUNDS)) begin
            rq.rsp_err <= 1'b1;
            rq.rsp_valid <= rq.gnt;
            st <= RESP;
          end else st <= WAIT;
        end
        WAIT: if (perm_done) begin
          rq.rsp_state <= perm_state_out;
          rq.rsp_err <= 1'b0;
          rq.rsp_valid <= rq.gnt;
          st <= RESP;
        end
`ifdef ASCON_ARB_TIMEOUT_EN
        else if (int'(cnt) == TIMEOUT - 1) begin
          rq.rsp_err <= 1'b1;
          rq.rsp_valid <= rq.gnt;
          perm_abort <= 1'b1;
          st <= RESP;
        end else cnt <= cnt + 1'b1;
`endif
        RESP: begin
          rq.gnt <= '0;
          rq.rsp_err <= 1'b0;
          ptr <= (int'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ascon_perm_arbiter.md
Name: ascon_perm_arbiter

Overview:
- Shares one Ascon 320-bit permutation core (permutation_loop-style, a/b-round runs) between N_REQ independent requesters, e.g. hash controller, AEAD controller, XOF controller.
- Round-robin arbitration.
- Drives the core's start/rounds/state interface.
- Waits for core completion and returns the permuted state to the granted requester with a one-cycle response pulse.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- MAX_ROUNDS, 12, largest legal round count; Ascon a=12, b=6/8.
- TIMEOUT, 64, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request level.
- req_rounds  in  4*N_REQ  packed round counts; slot i = bits [4i+3:4i].
- req_state  in  320*N_REQ  packed input states; slot i = bits [320i+319:320i]; layout {x4,x3,x2,x1,x0}.
- gnt  out  N_REQ  one-hot grant; held for the whole transaction.
- rsp_valid  out  N_REQ  one-cycle pulse to the served requester.
- rsp_err  out  1  qualifies rsp_valid; 1 = request rejected or aborted.
- rsp_state  out  320  result state; valid while any rsp_valid bit is high.
- perm_start  out  1  one-cycle start pulse to the core.
- perm_rounds  out  4  round count to the core.
- perm_state_in  out  320  core input state.
- perm_done  in  1  one-cycle completion pulse from the core.
- perm_state_out  in  320  core output state; valid with perm_done.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; RR pointer 0; internal registers 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is high, select the first set bit at or after the pointer, wrapping modulo N_REQ.
  - Register one-hot gnt, the sampled rounds and the sampled state; go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE (1 cycle):
  - If the latched rounds are 0 or greater than MAX_ROUNDS: no perm_start, set rsp_err=1, go to RESP.
  - Otherwise: perm_start=1, perm_rounds and perm_state_in driven from the latched copies, go to WAIT.
  - perm_rounds and perm_state_in stay stable until the state returns to IDLE.
- WAIT:
  - On perm_done, capture perm_state_out into rsp_state, set rsp_err=0, go to RESP.
  - perm_done seen in any state other than WAIT is ignored.
- RESP (1 cycle):
  - rsp_valid[g]=1 for the granted index g.
  - Advance the pointer to (g+1) mod N_REQ.
  - Deassert gnt next cycle; return to IDLE.
- Latency: req sampled at cycle 0; gnt high from cycle 1; perm_start at cycle 1; perm_done at cycle 1+D; rsp_valid at cycle 2+D.
  - Minimum request-to-request spacing is D+3 cycles.
- Requester rules:
  - Hold req until rsp_valid arrives; drop req the cycle after rsp_valid or later.
  - req_rounds and req_state are sampled only in IDLE, so later changes have no effect.
- req withdrawn mid-transaction: the transaction still completes and rsp_valid still pulses; the arbiter does not retract it.
- Back-to-back requests: a requester still holding req after its response is re-eligible, but the pointer guarantees every other pending requester is served first.
- All requesters idle: no core activity; perm_start is never asserted spuriously.
- Reset mid-operation:
  - Immediate return to IDLE; gnt, rsp_valid and perm_start forced to 0.
  - A core run already in flight is abandoned; its later perm_done is ignored.
- rsp_state holds its last value until the next capture; an error response also leaves it unchanged.

Optional Feature:
- Macro: ASCON_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If it reaches TIMEOUT without perm_done: go to RESP with rsp_err=1, leave rsp_state unchanged, and pulse perm_abort (extra 1-bit output) for one cycle.
  - perm_done arriving in the same cycle as the timeout wins: normal response.
- Undefined: no counter and no perm_abort port; WAIT lasts until perm_done.

Decomposition:
- Package ascon_pkg holds:
  - typedef ascon_state_t (logic [319:0]);
  - typedef rounds_t (logic [3:0]);
  - constants ASCON_ROUNDS_A=12 and ASCON_ROUNDS_B=6;
  - the arbiter FSM enum arb_state_e.
- One sub-module, rr_pick: combinational round-robin priority selector taking (req, ptr) and returning a one-hot grant plus its index.

Test Plan:
- Single requester: req=2'b01, rounds=12, state=IV-loaded {256'h0,64'h00400c0000000100}, core model D=12 -> perm_start at cycle 1, rsp_valid=2'b01 at cycle 14, rsp_state equals the golden a-permutation result, rsp_err=0.
- Contention: req=2'b11 held continuously, pointer 0 -> grant order 0,1,0,1; no requester is served twice in a row.
- Illegal rounds: rounds=0 or 13 -> no perm_start; rsp_valid pulses with rsp_err=1 at cycle 2 after sampling; rsp_state unchanged.
- Withdrawal: req[1] dropped during WAIT -> rsp_valid[1] still pulses; gnt clears after RESP.
- Reset mid-WAIT: rst_n low for 2 cycles, then the stale perm_done arrives -> all outputs 0, state IDLE, no rsp_valid pulse.
- ASCON_ARB_TIMEOUT_EN with TIMEOUT=64 and a core that never returns perm_done -> perm_abort and rsp_err=1 at WAIT cycle 64.
